a2bus_snoop_fifo: RTL

- Downstream consumer of the Apple II bus interface.
- Watches each completed bus data phase (the data_in_strobe pulse together with the latched addr/data/rw_n).
- Filters cycles against a parameterised address window and queues matching cycles in a FIFO.
- The PicoSoC (or any card-emulation logic) drains the FIFO through a valid/ready handshake; overflow is detected, counted and flagged sticky.

---
 rtl/a2bus_snoop_fifo.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/a2bus_snoop_fifo.sv
// Apple II bus snoop FIFO: filters completed bus data phases against an address
// window and queues matches for a valid/ready consumer, with sticky overflow.
module a2bus_snoop_fifo #(
  parameter int unsigned DEPTH         = 16,
  parameter logic [15:0] ADDR_BASE     = 16'hC080,
  parameter logic [15:0] ADDR_MASK     = 16'hFFF0,
  parameter bit          CAPTURE_READS = 1'b0
) (
  input  logic                     clk_logic_i,
  input  logic                     system_reset_n_i,
  input  logic                     enable_i,
  input  logic                     flush_i,
  input  logic                     clear_overflow_i,
  input  logic [15:0]              addr_i,
  input  logic [7:0]               data_i,
  input  logic                     rw_n_i,
  input  logic                     m2sel_n_i,
  input  logic                     data_in_strobe_i,
  output logic                     event_valid_o,
  input  logic                     event_ready_i,
  output logic [15:0]              event_addr_o,
  output logic [7:0]               event_data_o,
  output logic                     event_rw_n_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [15:0]              dropped_count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned AD = DEPTH - 1;

  typedef logic [24:0] entry_t;

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;

  entry_t        r_mem [AD];
  entry_t        r_out;
  logic          r_out_valid;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic [15:0]   r_dropped;

  entry_t        w_entry;
  logic          w_match;
  logic          w_push_req;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic          w_arr_empty;
  logic          w_mem_we;
  entry_t        w_out_nxt;
  logic          w_out_valid_nxt;
  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;
  logic [LW-1:0] w_level_nxt;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(AD - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) r_rst_sync <= '0;
    else                   r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_entry     = {addr_i, data_i, rw_n_i};
  assign w_match     = ((addr_i & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
  assign w_push_req  = data_in_strobe_i && enable_i && !m2sel_n_i && w_match &&
                       (CAPTURE_READS || !rw_n_i);
  assign w_pop       = r_out_valid && event_ready_i;
  assign w_full      = (r_level == LW'(DEPTH));
  assign w_push      = w_push_req && !flush_i && (!w_full || w_pop);
  assign w_drop      = w_push_req && !flush_i && w_full && !w_pop;
  // Array occupancy is level minus the output register.
  assign w_arr_empty = (r_level <= LW'(1));

  always_comb begin
    w_out_nxt       = r_out;
    w_out_valid_nxt = r_out_valid;
    w_wr_nxt        = r_wr;
    w_rd_nxt        = r_rd;
    w_level_nxt     = r_level;
    w_mem_we        = 1'b0;
    if (flush_i) begin
      w_out_valid_nxt = 1'b0;
      w_wr_nxt        = '0;
      w_rd_nxt        = '0;
      w_level_nxt     = '0;
    end else begin
      if (w_pop) begin
        if (!w_arr_empty) begin
          w_out_nxt = r_mem[r_rd];
          w_rd_nxt  = f_inc(r_rd);
        end else if (w_push) begin
          w_out_nxt = w_entry;
        end else begin
          w_out_valid_nxt = 1'b0;
        end
      end
      if (w_push) begin
        if (!r_out_valid) begin
          w_out_nxt       = w_entry;
          w_out_valid_nxt = 1'b1;
        end else if (!(w_pop && w_arr_empty)) begin
          w_mem_we = 1'b1;
          w_wr_nxt = f_inc(r_wr);
        end
      end
      if (w_push && !w_pop)      w_level_nxt = r_level + LW'(1);
      else if (!w_push && w_pop) w_level_nxt = r_level - LW'(1);
    end
  end

  always_ff @(posedge clk_logic_i) begin
    if (w_mem_we) r_mem[r_wr] <= w_entry;
  end

  always_ff @(posedge clk_logic_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_level     <= '0;
    end else begin
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_wr        <= w_wr_nxt;
      r_rd        <= w_rd_nxt;
      r_level     <= w_level_nxt;
    end
  end

  // A drop coinciding with a clear leaves exactly one drop recorded.
  always_ff @(posedge clk_logic_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else if (clear_overflow_i) begin
      r_overflow <= w_drop;
      r_dropped  <= {15'd0, w_drop};
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
    end
  end

  assign event_valid_o   = r_out_valid;
  assign event_addr_o    = r_out[24:9];
  assign event_data_o    = r_out[8:1];
  assign event_rw_n_o    = r_out[0];
  assign level_o         = r_level;
  assign overflow_o      = r_overflow;
  assign dropped_count_o = r_dropped;

endmodule
